alu_seq_unit: RTL and testbench

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

---
 rtl/alu_seq_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// -----------------------------------------------------------------------------
// alu_seq_unit
//   Small sequential ALU. Logic/arith ops and slt complete in one cycle.
//   Shifts run one bit per clock, and mul runs as a WIDTH-step shift-add.
//   Operands are captured when a request is accepted, so the caller may change
//   the inputs freely while the unit is busy.
//
// Ports
//   clk     in   sole clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   request, sampled only while idle
//   opcode  in   6-bit instruction opcode (decoded when aluop = 2)
//   aluop   in   0=add 1=sub 2=decode opcode 3=add
//   a, b    in   operands (a is also the shift source)
//   shamt   in   shift amount
//   busy    out  high while an operation is in flight
//   done    out  one-cycle pulse, result/zero/ovf valid
//   result  out  registered result, held until the next done
//   zero    out  result == 0, registered with result
//   ovf     out  signed overflow for add/sub, else 0
// -----------------------------------------------------------------------------
module alu_seq_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter bit MUL_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [5:0]         opcode,
    input  logic [1:0]         aluop,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               ovf
);

    // One extra bit so the counter can hold WIDTH for the multiplier.
    localparam int CNT_W = SHAMT_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
        OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_MUL
    } op_t;

    state_t             state_q, state_d;
    op_t                op_q, op_d, op_new;
    logic [WIDTH-1:0]   work_q, work_d;      // shift register / multiplicand
    logic [WIDTH-1:0]   mplier_q, mplier_d;  // multiplier, consumed LSB first
    logic [WIDTH-1:0]   acc_q, acc_d;        // product accumulator
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   sum, diff, alu_res, shift_res, acc_step;
    logic               add_ovf, sub_ovf, alu_ovf;

    function automatic op_t decode(input logic [1:0] aluop_v, input logic [5:0] opc);
        op_t op;
        op = OP_ADD;
        case (aluop_v)
            2'd1: op = OP_SUB;
            2'd2: begin
                case (opc)
                    6'b000001:           op = OP_SUB;
                    6'b010000, 6'b010001: op = OP_AND;
                    6'b010010:           op = OP_OR;
                    6'b010011:           op = OP_XOR;
                    6'b011000:           op = OP_SLL;
                    6'b011001:           op = OP_SRL;
                    6'b011010:           op = OP_SRA;
                    6'b100110, 6'b100111: op = OP_SLT;
                    6'b101000:           op = MUL_EN ? OP_MUL : OP_ADD;
                    default:             op = OP_ADD;
                endcase
            end
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            work_q   <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    // ---------------- next-state / datapath ----------------
    always_comb begin
        op_new  = decode(aluop, opcode);
        sum     = a + b;
        diff    = a - b;
        // Overflow when operands agree in sign (add) or differ (sub) and the
        // result sign disagrees with a.
        add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
        sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

        alu_res = sum;
        alu_ovf = add_ovf;
        case (op_new)
            OP_SUB: begin alu_res = diff;  alu_ovf = sub_ovf; end
            OP_AND: begin alu_res = a & b; alu_ovf = 1'b0;    end
            OP_OR:  begin alu_res = a | b; alu_ovf = 1'b0;    end
            OP_XOR: begin alu_res = a ^ b; alu_ovf = 1'b0;    end
            OP_SLT: begin
                alu_res    = '0;
                alu_res[0] = $signed(a) < $signed(b);
                alu_ovf    = 1'b0;
            end
            default: ;
        endcase

        case (op_q)
            OP_SLL:  shift_res = work_q << 1;
            OP_SRA:  shift_res = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: shift_res = work_q >> 1;
        endcase

        acc_step = acc_q + (mplier_q[0] ? work_q : '0);

        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d = op_new;
                    case (op_new)
                        OP_SLL, OP_SRL, OP_SRA: begin
                            if (shamt == '0) begin
                                done_d   = 1'b1;
                                result_d = a;
                                ovf_d    = 1'b0;
                            end else begin
                                state_d = ST_SHIFT;
                                work_d  = a;
                                cnt_d   = {1'b0, shamt};
                            end
                        end
                        OP_MUL: begin
                            state_d  = ST_MUL;
                            work_d   = a;
                            mplier_d = b;
                            acc_d    = '0;
                            cnt_d    = CNT_W'(WIDTH);
                        end
                        default: begin
                            done_d   = 1'b1;
                            result_d = alu_res;
                            ovf_d    = alu_ovf;
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                work_d = shift_res;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    result_d = shift_res;
                    ovf_d    = 1'b0;
                end
            end
            ST_MUL: begin
                acc_d    = acc_step;
                work_d   = work_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    result_d = acc_step;
                    ovf_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Zero only moves with a completed result so it stays paired with it
        // (and stays 0 after reset even though result is 0).
        zero_d = done_d ? (result_d == '0) : zero_q;
    end

    // ---------------- outputs ----------------
    always_comb begin
        busy   = (state_q != ST_IDLE);
        done   = done_q;
        result = result_q;
        zero   = zero_q;
        ovf    = ovf_q;
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
module tb_alu_seq_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  opcode = '0;
    logic [1:0]  aluop = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  shamt = '0;
    logic        busy, done, zero, ovf;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_res, prev_res;
    logic        exp_ovf, prev_ovf, prev_zero;
    int          exp_lat;
    logic [1:0]  cur_al;
    logic [5:0]  cur_opc;
    logic [31:0] cur_a, cur_b;
    logic [4:0]  cur_sh;

    localparam longint MAXS = 64'sh7FFF_FFFF;
    localparam longint MINS = -64'sh8000_0000;

    alu_seq_unit #(.WIDTH(32), .SHAMT_W(5), .MUL_EN(1'b1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .opcode (opcode),
        .aluop  (aluop),
        .a      (a),
        .b      (b),
        .shamt  (shamt),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: result, overflow and completion latency (edges after the
    // accepting edge) straight from the operation definitions.
    function automatic void model(input logic [1:0] al, input logic [5:0] opc,
                                  input logic [31:0] x, input logic [31:0] y,
                                  input logic [4:0] sh,
                                  output logic [31:0] r, output logic v, output int lat);
        int     op;
        longint s;
        logic [63:0] p;
        op = 0;
        if (al == 2'd1) op = 1;
        else if (al == 2'd2) begin
            case (opc)
                6'b000001:            op = 1;
                6'b010000, 6'b010001: op = 2;
                6'b010010:            op = 3;
                6'b010011:            op = 4;
                6'b011000:            op = 5;
                6'b011001:            op = 6;
                6'b011010:            op = 7;
                6'b100110, 6'b100111: op = 8;
                6'b101000:            op = 9;
                default:              op = 0;
            endcase
        end
        v = 1'b0;
        lat = 0;
        r = '0;
        case (op)
            0: begin
                s = longint'($signed(x)) + longint'($signed(y));
                r = x + y;
                v = (s > MAXS) || (s < MINS);
            end
            1: begin
                s = longint'($signed(x)) - longint'($signed(y));
                r = x - y;
                v = (s > MAXS) || (s < MINS);
            end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: begin r = x << sh; lat = int'(sh); end
            6: begin r = x >> sh; lat = int'(sh); end
            7: begin r = $signed(x) >>> sh; lat = int'(sh); end
            8: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: begin
                p = {32'b0, x} * {32'b0, y};
                r = p[31:0];
                lat = 32;
            end
        endcase
    endfunction

    // Present a request in the current (idle or done) cycle.
    task automatic issue(input logic [1:0] al, input logic [5:0] opc,
                         input logic [31:0] x, input logic [31:0] y, input logic [4:0] sh);
        aluop = al; opcode = opc; a = x; b = y; shamt = sh; start = 1'b1;
        cur_al = al; cur_opc = opc; cur_a = x; cur_b = y; cur_sh = sh;
        model(al, opc, x, y, sh, exp_res, exp_ovf, exp_lat);
    endtask

    // inject: -1 none, -2 random starts while busy, n>=0 one start at busy cycle n.
    task automatic wait_done(input int inject);
        int cyc;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            check("busy", busy, 1);
            check("hold_res", result, prev_res);
            check("hold_zero", zero, prev_zero);
            start  = (inject == -2) ? 1'($urandom_range(0, 1)) : (cyc == inject);
            a      = $urandom;
            b      = $urandom;
            opcode = 6'($urandom);
            aluop  = 2'($urandom);
            shamt  = 5'($urandom);
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("latency", cyc, exp_lat);
        check("busy_at_done", busy, 0);
        check("result", result, exp_res);
        check("zero", zero, exp_res == 32'd0);
        check("ovf", ovf, exp_ovf);
        prev_res  = exp_res;
        prev_zero = (exp_res == 32'd0);
        prev_ovf  = exp_ovf;
        $display("op aluop=%0d opc=%b a=%h b=%h sh=%0d -> result=%h ovf=%0d lat=%0d",
                 cur_al, cur_opc, cur_a, cur_b, cur_sh, result, ovf, cyc);
    endtask

    task automatic idle_cycle();
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        check("res_held", result, prev_res);
        check("ovf_held", ovf, prev_ovf);
    endtask

    logic [5:0]  opc_tab [0:14] = '{6'h00, 6'h02, 6'h01, 6'h10, 6'h11, 6'h12, 6'h13,
                                    6'h18, 6'h19, 6'h1A, 6'h26, 6'h27, 6'h28, 6'h3F, 6'h05};
    logic [31:0] edge_tab [0:4] = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1};

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return edge_tab[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int pulses;
        prev_res = '0; prev_zero = 1'b0; prev_ovf = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        idle_cycle();

        // Add overflow
        issue(2'd2, 6'b000000, 32'h7FFF_FFFF, 32'h1, 5'd0);
        wait_done(-1);
        idle_cycle();
        // Sub zero flag
        issue(2'd1, 6'b111111, 32'd5, 32'd5, 5'd0);
        wait_done(-1);
        idle_cycle();
        // Arithmetic shift right by 4
        issue(2'd2, 6'b011010, 32'h8000_0000, 32'h0, 5'd4);
        wait_done(-1);
        idle_cycle();
        // Shift by zero completes in one cycle
        issue(2'd2, 6'b011000, 32'h1234_5678, 32'h0, 5'd0);
        wait_done(-1);
        idle_cycle();
        // Multiply with a stray start while busy
        issue(2'd2, 6'b101000, 32'h0000_FFFF, 32'h0001_0001, 5'd0);
        wait_done(3);
        idle_cycle();
        // slt then back-to-back add
        issue(2'd2, 6'b100110, 32'hFFFF_FFFF, 32'h0, 5'd0);
        wait_done(-1);
        issue(2'd0, 6'b000000, 32'd10, 32'd20, 5'd0);
        wait_done(-1);
        issue(2'd2, 6'b011001, 32'hF000_000F, 32'h0, 5'd3);
        wait_done(-1);
        idle_cycle();

        // Reset in the middle of a multiply
        issue(2'd2, 6'b101000, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0);
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_result", result, 0);
        check("arst_zero", zero, 0);
        check("arst_ovf", ovf, 0);
        prev_res = '0; prev_zero = 1'b0; prev_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("no_done_after_rst", pulses, 0);
        check("idle_after_rst", busy, 0);
        issue(2'd2, 6'b010011, 32'hA5A5_A5A5, 32'hFFFF_0000, 5'd0);
        wait_done(-1);
        idle_cycle();

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            logic [1:0] al;
            logic [4:0] sh;
            al = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd2;
            sh = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            issue(al, opc_tab[$urandom_range(0, 14)], pick_operand(), pick_operand(), sh);
            wait_done($urandom_range(0, 1) == 0 ? -2 : -1);
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
